// File: rtl/resp_btn_conditioner.sv
// Response-button conditioner: synchronizes and debounces a raw button, emits one
// strobe per accepted press, counts presses and flags a button held high too long.
module resp_btn_conditioner #(
   parameter int unsigned DB_CYCLES    = 4,
   parameter int unsigned STUCK_CYCLES = 64
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       btn_raw,
   output logic       resp_pulse,
   output logic       btn_level,
   output logic       stuck,
   output logic [7:0] press_cnt,
   output logic [1:0] state_o
);

   typedef enum logic [1:0] {
      ARM     = 2'd0,
      IDLE    = 2'd1,
      PRESSED = 2'd2,
      STUCK   = 2'd3
   } state_t;

   localparam int unsigned      HOLD_W   = $clog2(STUCK_CYCLES + 1);
   localparam logic [7:0]        DB_LAST  = 8'(DB_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(STUCK_CYCLES);

   logic              sync1_q, sync2_q;
   logic [7:0]        db_cnt_q, db_cnt_d;
   logic              level_q, level_d;
   logic [7:0]        arm_cnt_q, arm_cnt_d;
   logic [HOLD_W-1:0] hold_q, hold_d;
   state_t            state_q, state_d;
   logic              pulse_q, pulse_d;
   logic              stuck_q, stuck_d;
   logic [7:0]        cnt_q, cnt_d;
   logic              arm_ok, rise, fall, hold_full;

   // Debounce: level flips only after DB_CYCLES consecutive differing samples.
   always_comb begin
      db_cnt_d = db_cnt_q;
      level_d  = level_q;
      if (sync2_q == level_q) begin
         db_cnt_d = '0;
      end else if (db_cnt_q == DB_LAST) begin
         level_d  = ~level_q;
         db_cnt_d = '0;
      end else begin
         db_cnt_d = db_cnt_q + 8'd1;
      end
   end

   always_comb begin
      hold_d = '0;
      if (level_q && level_d) begin
         hold_d = (hold_q == HOLD_MAX) ? hold_q : hold_q + HOLD_W'(1);
      end
   end

   // Arming requires a clean released button seen since reset.
   always_comb begin
      arm_ok    = 1'b0;
      arm_cnt_d = '0;
      if (state_q == ARM && !sync2_q) begin
         if (arm_cnt_q == DB_LAST) arm_ok = 1'b1;
         else                      arm_cnt_d = arm_cnt_q + 8'd1;
      end
   end

   assign rise      = level_d & ~level_q;
   assign fall      = ~level_d & level_q;
   assign hold_full = (hold_d == HOLD_MAX);

   always_comb begin
      state_d = state_q;
      pulse_d = 1'b0;
      case (state_q)
         ARM: begin
            if (arm_ok)         state_d = IDLE;
            else if (hold_full) state_d = STUCK;
         end
         IDLE: begin
            if (rise) begin
               state_d = PRESSED;
               pulse_d = 1'b1;
            end
         end
         PRESSED: begin
            if (fall)           state_d = IDLE;
            else if (hold_full) state_d = STUCK;
         end
         STUCK: begin
            if (fall) state_d = IDLE;
         end
         default: state_d = ARM;
      endcase
      stuck_d = (state_d == STUCK);
      cnt_d   = (pulse_d && cnt_q != 8'hFF) ? cnt_q + 8'd1 : cnt_q;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         db_cnt_q  <= '0;
         level_q   <= 1'b0;
         arm_cnt_q <= '0;
         hold_q    <= '0;
         state_q   <= ARM;
         pulse_q   <= 1'b0;
         stuck_q   <= 1'b0;
         cnt_q     <= '0;
      end else begin
         sync1_q   <= btn_raw;
         sync2_q   <= sync1_q;
         db_cnt_q  <= db_cnt_d;
         level_q   <= level_d;
         arm_cnt_q <= arm_cnt_d;
         hold_q    <= hold_d;
         state_q   <= state_d;
         pulse_q   <= pulse_d;
         stuck_q   <= stuck_d;
         cnt_q     <= cnt_d;
      end
   end

   assign resp_pulse = pulse_q;
   assign btn_level  = level_q;
   assign stuck      = stuck_q;
   assign press_cnt  = cnt_q;
   assign state_o    = state_q;

endmodule

// File: tb/tb_resp_btn_conditioner.sv
// Bench for resp_btn_conditioner: directed scenarios plus random button activity,
// checked against a sample-window reference model through a pulse scoreboard.
module tb_resp_btn_conditioner;

   localparam int DB  = 4;
   localparam int STK = 64;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       btn_raw = 1'b0;
   logic       resp_pulse, btn_level, stuck;
   logic [7:0] press_cnt;
   logic [1:0] state_o;

   resp_btn_conditioner #(.DB_CYCLES(DB), .STUCK_CYCLES(STK)) dut (
      .clock      (clock),
      .reset      (reset),
      .btn_raw    (btn_raw),
      .resp_pulse (resp_pulse),
      .btn_level  (btn_level),
      .stuck      (stuck),
      .press_cnt  (press_cnt),
      .state_o    (state_o)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   logic [31:0] exp_q[$];

   // Reference model state
   logic m_s1, m_s2, m_level, m_armed, m_stuck;
   int   m_run, m_cnt;
   logic smp_q[$];

   // Scenario observations
   int   dut_pulses = 0;
   int   lvl_rise_cyc = 0, lvl_fall_cyc = 0, stk_rise_cyc = 0, stk_fall_cyc = 0;
   logic stuck_seen = 1'b0;
   logic prev_lvl = 1'b0, prev_stk = 1'b0;
   int   last_drive_cyc = 0;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   // Model: level follows a window of the last DB synchronized samples since reset.
   initial begin
      logic smp, prev, all_diff, all_zero;
      m_s1 = 0; m_s2 = 0; m_level = 0; m_armed = 0; m_stuck = 0; m_run = 0; m_cnt = 0;
      forever begin
         @(posedge clock);
         cyc++;
         if (reset) begin
            m_s1 = 0; m_s2 = 0; m_level = 0; m_armed = 0; m_stuck = 0;
            m_run = 0; m_cnt = 0;
            smp_q.delete();
         end else begin
            smp  = m_s2;
            m_s2 = m_s1;
            m_s1 = btn_raw;
            smp_q.push_back(smp);
            if (smp_q.size() > DB) void'(smp_q.pop_front());
            prev     = m_level;
            all_diff = (smp_q.size() == DB);
            all_zero = (smp_q.size() == DB);
            foreach (smp_q[i]) begin
               if (smp_q[i] == m_level) all_diff = 0;
               if (smp_q[i])            all_zero = 0;
            end
            if (all_diff) m_level = !m_level;
            if (m_armed && !prev && m_level) begin
               if (m_cnt < 255) m_cnt++;
               exp_q.push_back(32'(cyc));
            end
            if (all_zero) m_armed = 1;
            m_run   = (prev && m_level) ? m_run + 1 : 0;
            m_stuck = m_level && (m_run >= STK);
         end
      end
   end

   // Monitor: compare outputs each cycle and pop expected strobes.
   initial begin
      logic [1:0] m_state;
      logic       exp_pulse;
      forever begin
         @(negedge clock);
         m_state = m_stuck ? 2'd3 : (!m_armed ? 2'd0 : (m_level ? 2'd2 : 2'd1));
         check("btn_level", btn_level, m_level);
         check("stuck", stuck, m_stuck);
         check("state", state_o, m_state);
         check("press_cnt", press_cnt, 32'(m_cnt));
         if (resp_pulse || (exp_q.size() > 0 && exp_q[0] <= 32'(cyc))) begin
            exp_pulse = (exp_q.size() > 0 && exp_q[0] == 32'(cyc));
            check("resp_pulse", resp_pulse, exp_pulse);
            if (exp_q.size() > 0 && exp_q[0] <= 32'(cyc)) void'(exp_q.pop_front());
         end
         if (resp_pulse) dut_pulses++;
         if (stuck) stuck_seen = 1'b1;
         if (btn_level && !prev_lvl) lvl_rise_cyc = cyc;
         if (!btn_level && prev_lvl) lvl_fall_cyc = cyc;
         if (stuck && !prev_stk) stk_rise_cyc = cyc;
         if (!stuck && prev_stk) stk_fall_cyc = cyc;
         prev_lvl = btn_level;
         prev_stk = stuck;
      end
   end

   task automatic drive(input logic v, input int n);
      @(negedge clock);
      btn_raw = v;
      last_drive_cyc = cyc;
      repeat (n - 1) @(negedge clock);
   endtask

   task automatic do_reset(input int n);
      @(negedge clock);
      reset = 1'b1;
      repeat (n) @(negedge clock);
      reset = 1'b0;
   endtask

   task automatic clear_obs();
      dut_pulses = 0;
      stuck_seen = 1'b0;
   endtask

   initial begin
      int press_at;
      // Reset state
      do_reset(3);
      check("rst_level", btn_level, 0);
      check("rst_pulse", resp_pulse, 0);
      check("rst_stuck", stuck, 0);
      check("rst_cnt", press_cnt, 0);
      check("rst_state", state_o, 0);

      // Clean press: strobe 6 cycles after the first high sample
      clear_obs();
      drive(0, 10);
      drive(1, 20);
      press_at = last_drive_cyc;
      check("s1_rise_latency", 32'(lvl_rise_cyc - press_at), 6);
      check("s1_pulses", 32'(dut_pulses), 1);
      check("s1_cnt", press_cnt, 1);
      check("s1_no_stuck", stuck_seen, 0);
      drive(0, 10);

      // Bounce and short glitches are rejected
      do_reset(1);
      clear_obs();
      drive(0, 10);
      for (int i = 0; i < 12; i++) drive(logic'((i % 2) == 0), 1);
      drive(0, 8);
      for (int i = 0; i < 3; i++) begin
         drive(1, 3);
         drive(0, 6);
      end
      check("s2_no_glitch_pulse", 32'(dut_pulses), 0);
      drive(1, 20);
      check("s2_pulses", 32'(dut_pulses), 1);
      check("s2_cnt", press_cnt, 1);
      drive(0, 10);

      // Long hold: stuck after 64 cycles of high level, clears with the release
      do_reset(1);
      clear_obs();
      drive(0, 10);
      drive(1, 100);
      press_at = last_drive_cyc;
      check("s3_pulses", 32'(dut_pulses), 1);
      check("s3_level_rise", 32'(lvl_rise_cyc - press_at), 6);
      check("s3_stuck_rise", 32'(stk_rise_cyc - press_at), 6 + STK);
      drive(0, 12);
      check("s3_level_fall", 32'(lvl_fall_cyc - last_drive_cyc), 6);
      check("s3_stuck_fall", 32'(stk_fall_cyc - last_drive_cyc), 6);

      // Button held through reset: no strobe until released
      drive(1, 5);
      do_reset(3);
      clear_obs();
      drive(1, 80);
      check("s4_no_pulse", 32'(dut_pulses), 0);
      check("s4_stuck", stuck, 1);
      drive(0, 10);
      drive(1, 20);
      check("s4_pulses", 32'(dut_pulses), 1);
      check("s4_cnt", press_cnt, 1);
      drive(0, 10);

      // Single-cycle reset while pressed
      do_reset(1);
      drive(0, 10);
      drive(1, 15);
      check("s5_pressed_state", state_o, 2);
      do_reset(1);
      clear_obs();
      check("s5_level", btn_level, 0);
      check("s5_pulse", resp_pulse, 0);
      check("s5_stuck", stuck, 0);
      check("s5_cnt", press_cnt, 0);
      check("s5_state", state_o, 0);
      drive(1, 80);
      check("s5_no_pulse", 32'(dut_pulses), 0);
      drive(0, 10);

      // Press counter saturation
      do_reset(1);
      clear_obs();
      drive(0, 10);
      for (int i = 0; i < 260; i++) begin
         drive(1, 10);
         drive(0, 10);
      end
      check("s6_pulses", 32'(dut_pulses), 260);
      check("s6_cnt_sat", press_cnt, 255);

      // Random activity with occasional resets and long holds
      do_reset(1);
      for (int i = 0; i < 300; i++) begin
         int n;
         if ($urandom_range(0, 39) == 0) do_reset($urandom_range(1, 3));
         n = ($urandom_range(0, 9) == 0) ? $urandom_range(60, 80) : $urandom_range(1, 12);
         drive(logic'($urandom_range(0, 1)), n);
      end
      drive(0, 20);
      check("pending_pulses", 32'(exp_q.size()), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/resp_btn_conditioner.md
RESP_BTN_CONDITIONER -- requirements
Module: resp_btn_conditioner

Interface
REQ-001 SHALL provide parameter DB_CYCLES, default 4, number of consecutive synchronized samples needed to accept a level change (range 2..255).
REQ-002 SHALL provide parameter STUCK_CYCLES, default 64, number of cycles the debounced level may stay high before it is flagged stuck (range 4..65535).
REQ-003 SHALL have port clock  in  1  single system clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port btn_raw  in  1  raw, asynchronous, bouncing response button.
REQ-006 SHALL have port resp_pulse  out  1  one-cycle accepted-press strobe; drives the downstream alertness detector's in_put.
REQ-007 SHALL have port btn_level  out  1  debounced button level.
REQ-008 SHALL have port stuck  out  1  button held high for STUCK_CYCLES or more.
REQ-009 SHALL have port press_cnt  out  8  count of accepted presses, saturating.

Function
REQ-010 SHALL pass btn_raw through a 2-flop synchronizer; the second flop output is btn_s.
REQ-011 SHALL keep a debounce counter: it clears whenever btn_s equals btn_level, and increments whenever they differ.
REQ-012 SHALL toggle btn_level and clear the debounce counter on the edge where btn_s still differs and the counter equals DB_CYCLES-1.
REQ-013 SHALL therefore make btn_level change DB_CYCLES+2 cycles after btn_raw is first sampled at a new stable value (6 cycles at default).
REQ-014 SHALL never change btn_level on an input pulse or glitch shorter than DB_CYCLES synchronized cycles.
REQ-015 SHALL implement the FSM states ARM, IDLE, PRESSED, STUCK.
REQ-016 SHALL handle ARM as follows:
- entered on reset;
- moves to IDLE after btn_s is 0 on DB_CYCLES consecutive cycles;
- moves to STUCK when btn_level has been 1 for STUCK_CYCLES cycles;
- never asserts resp_pulse.
REQ-017 SHALL handle IDLE as follows: on a btn_level 0->1 transition, move to PRESSED and assert resp_pulse in the same cycle btn_level first reads 1.
REQ-018 SHALL handle PRESSED as follows:
- a hold counter counts cycles with btn_level=1;
- the counter is cleared on entry;
- btn_level falling moves to IDLE;
- the hold count reaching STUCK_CYCLES moves to STUCK.
REQ-019 SHALL handle STUCK as follows:
- stuck=1 for as long as the FSM is in STUCK;
- btn_level falling moves to IDLE, and stuck=0 in that same cycle;
- no resp_pulse is issued.
REQ-020 SHALL make resp_pulse exactly one cycle wide, with at most one pulse per debounced press, however long the button is held.
REQ-021 SHALL increment press_cnt by 1 on each resp_pulse and saturate it at 255 (no wrap-around).
REQ-022 SHALL make the hold counter wide enough for STUCK_CYCLES and saturate it at STUCK_CYCLES.
REQ-023 SHALL register all outputs, with no combinational path from btn_raw to any output.

Reset
REQ-024 SHALL, while reset=1 at a clock edge, clear:
- both synchronizer flops;
- the debounce counter and the hold counter;
- press_cnt, btn_level, resp_pulse and stuck, which read 0 in the cycle after that edge;
- the FSM, which is set to ARM.
REQ-025 SHALL let reset asserted mid-press abort the press with no pulse; the module then re-arms per REQ-016, so a button held through reset never produces resp_pulse until it has been released.
REQ-026 SHALL let reset override all other events in the same cycle.

Verification (DB_CYCLES=4, STUCK_CYCLES=64)
REQ-027 SHALL be verified by the scenario: reset, then btn_raw=0 for 10 cycles, then btn_raw=1 for 20 cycles -> a single resp_pulse 6 cycles after the first high sample, press_cnt=1, stuck=0 throughout.
REQ-028 SHALL be verified by the scenario: after arming, btn_raw toggles every cycle for 12 cycles, then 3-cycle high glitches, then stable high -> no pulse during bouncing or glitches, exactly one pulse after the stable high, press_cnt=1.
REQ-029 SHALL be verified by the scenario: a stable press held 100 cycles -> one pulse; stuck=1 exactly 64 cycles after btn_level rises; btn_raw low -> btn_level, and with it stuck, fall 6 cycles later.
REQ-030 SHALL be verified by the scenario: btn_raw=1 before, during and after reset for 80 cycles -> no resp_pulse and stuck asserted; then release for 10 cycles and press -> one pulse, press_cnt=1.
REQ-031 SHALL be verified by the scenario: a single-cycle reset during PRESSED -> all outputs 0 next cycle and state ARM; keeping the button held produces no pulse.
REQ-032 SHALL be verified by the scenario: 260 clean press/release pairs of 10 cycles each -> 260 pulses, press_cnt saturates at 255 and holds.
